// File: rtl/cpu6_bus_arbiter_if.sv
// cpu6_bus_arbiter_if: CPU/DMA request, ack and memory-side bus signals of the Centurion bus arbiter
interface cpu6_bus_arbiter_if #(parameter int NUM_DMA = 2);
  logic                   cpu_req;
  logic                   cpu_we;
  logic [15:0]            cpu_addr;
  logic [7:0]             cpu_wdata;
  logic                   cpu_ack;
  logic [NUM_DMA-1:0]     dma_req;
  logic [NUM_DMA-1:0]     dma_we;
  logic [16*NUM_DMA-1:0]  dma_addr;
  logic [8*NUM_DMA-1:0]   dma_wdata;
  logic [NUM_DMA-1:0]     dma_ack;
  logic [7:0]             rdata;
  logic                   bus_error;
  logic [15:0]            mem_addr;
  logic [7:0]             mem_wdata;
  logic                   mem_re;
  logic                   mem_we;
  logic [7:0]             mem_rdata;
  logic                   mem_ready;
  logic [2:0]             owner;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata, mem_ready,
    output cpu_ack, dma_ack, rdata, bus_error, mem_addr, mem_wdata, mem_re, mem_we, owner
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata, mem_ready,
    input  cpu_ack, dma_ack, rdata, bus_error, mem_addr, mem_wdata, mem_re, mem_we, owner
  );
endinterface

// File: rtl/cpu6_bus_arbiter.sv
// cpu6_bus_arbiter: CPU6/DMA Centurion bus arbiter and access sequencer; define CPU6_BUS_TIMEOUT_EN for the WAIT timeout
module cpu6_bus_arbiter #(
  parameter int NUM_DMA        = 2,
  parameter int WAIT_STATES    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                 clock,
  input logic                 reset,
  cpu6_bus_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;
  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [1:0]           rr_q, rr_d;
  logic                 prev_dma_q, prev_dma_d;
  logic [2:0]           owner_q, owner_d;
  logic [15:0]          mem_addr_q, mem_addr_d;
  logic [7:0]           mem_wdata_q, mem_wdata_d;
  logic                 re_q, re_d;
  logic                 we_q, we_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 cpu_ack_q, cpu_ack_d;
  logic [NUM_DMA-1:0]   dma_ack_q, dma_ack_d;
  logic                 dma_hit, gnt_dma, ready_ok, tmo_hit, fin;
  logic [1:0]           dma_win;
`ifdef CPU6_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 err_q, err_d;
  assign tmo_hit = (state_q == WAIT) && !ready_ok && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign bus.bus_error = err_q;
`else
  assign tmo_hit = 1'b0;
  assign bus.bus_error = 1'b0;
`endif
  assign ready_ok = (cnt_q == 3'd0) && bus.mem_ready;
  assign fin      = (state_q == WAIT) && (ready_ok || tmo_hit);
  assign gnt_dma  = dma_hit && !(prev_dma_q && bus.cpu_req);
  // round-robin search from rr_q; iterating downward leaves the first port in search order as winner
  always_comb begin
    dma_hit = 1'b0;
    dma_win = 2'd0;
    for (int k = NUM_DMA - 1; k >= 0; k--)
      if (bus.dma_req[(int'(rr_q) + k) % NUM_DMA]) begin
        dma_hit = 1'b1;
        dma_win = 2'((int'(rr_q) + k) % NUM_DMA);
      end
  end
  // next-state, grant capture, strobes, read data and ack pulses
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    prev_dma_d  = prev_dma_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    re_d        = re_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = '0;
`ifdef CPU6_BUS_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE:
        if (gnt_dma || bus.cpu_req) begin
          state_d     = ADDR;
          owner_d     = gnt_dma ? {1'b0, dma_win} + 3'd1 : 3'd0;
          mem_addr_d  = gnt_dma ? bus.dma_addr[16*dma_win +: 16] : bus.cpu_addr;
          mem_wdata_d = gnt_dma ? bus.dma_wdata[8*dma_win +: 8] : bus.cpu_wdata;
          we_d        = gnt_dma ? bus.dma_we[dma_win] : bus.cpu_we;
          re_d        = !we_d;
          prev_dma_d  = gnt_dma;
          rr_d        = !gnt_dma ? rr_q : (dma_win == 2'(NUM_DMA - 1)) ? 2'd0 : dma_win + 2'd1;
        end
      ADDR: begin
        state_d = WAIT;
        cnt_d   = 3'(WAIT_STATES);
`ifdef CPU6_BUS_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      WAIT: begin
        cnt_d = (cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
`ifdef CPU6_BUS_TIMEOUT_EN
        tmo_d = tmo_q + TW'(1);
        err_d = fin ? tmo_hit : err_q;
`endif
        if (fin) begin
          state_d   = DONE;
          re_d      = 1'b0;
          we_d      = 1'b0;
          rdata_d   = tmo_hit ? 8'hFF : re_q ? bus.mem_rdata : rdata_q;
          cpu_ack_d = (owner_q == 3'd0);
          dma_ack_d = (owner_q == 3'd0) ? '0 : NUM_DMA'(1) << (owner_q - 3'd1);
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = 3'd0;
      end
    endcase
  end
  // state and registered outputs; asynchronous reset aborts any access in flight
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      rr_q        <= 2'd0;
      prev_dma_q  <= 1'b0;
      owner_q     <= 3'd0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 8'd0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      rdata_q     <= 8'd0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= '0;
`ifdef CPU6_BUS_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      prev_dma_q  <= prev_dma_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      re_q        <= re_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
`ifdef CPU6_BUS_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_re    = re_q;
  assign bus.mem_we    = we_q;
  assign bus.owner     = owner_q;
endmodule

// File: tb/tb_cpu6_bus_arbiter.sv
// tb_cpu6_bus_arbiter: directed self-checking bench for cpu6_bus_arbiter
module tb_cpu6_bus_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  cpu6_bus_arbiter_if #(.NUM_DMA(2)) bus ();
  cpu6_bus_arbiter #(.NUM_DMA(2), .WAIT_STATES(1), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
    bus.mem_rdata = 0; bus.mem_ready = 1;
    reset = 1;
    tick(); tick();
    checks++; if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_strobes got re=%b we=%b exp 0 0", bus.mem_re, bus.mem_we); end
    checks++; if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 8'h0) begin failures++; $display("FAIL reset_mem got addr=%h wdata=%h exp 0 0", bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.cpu_ack !== 1'b0 || bus.dma_ack !== 2'b00 || bus.bus_error !== 1'b0) begin failures++; $display("FAIL reset_acks got cpu=%b dma=%b err=%b exp 0", bus.cpu_ack, bus.dma_ack, bus.bus_error); end
    checks++; if (bus.owner !== 3'd0 || bus.rdata !== 8'h00) begin failures++; $display("FAIL reset_owner_rdata got owner=%0d rdata=%h exp 0 00", bus.owner, bus.rdata); end
    reset = 0;
    tick();
    checks++; if (bus.mem_re !== 1'b0 || bus.owner !== 3'd0) begin failures++; $display("FAIL idle_no_req got re=%b owner=%0d exp 0 0", bus.mem_re, bus.owner); end
  endtask
  task automatic test_cpu_read();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0100; bus.mem_rdata = 8'h5A; bus.mem_ready = 1;
    tick();
    checks++; if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0100) begin failures++; $display("FAIL rd_addr got re=%b we=%b addr=%h exp 1 0 0100", bus.mem_re, bus.mem_we, bus.mem_addr); end
    tick(); tick();
    checks++; if (bus.cpu_ack !== 1'b0 || bus.mem_re !== 1'b1) begin failures++; $display("FAIL rd_early got ack=%b re=%b exp 0 1", bus.cpu_ack, bus.mem_re); end
    tick();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.rdata !== 8'h5A || bus.mem_re !== 1'b0) begin failures++; $display("FAIL rd_ack got ack=%b rdata=%h re=%b exp 1 5a 0", bus.cpu_ack, bus.rdata, bus.mem_re); end
    bus.cpu_req = 0;
    tick();
    checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL rd_ack_pulse got ack=%b exp 0", bus.cpu_ack); end
  endtask
  task automatic test_cpu_write_wait();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'hF200; bus.cpu_wdata = 8'hC3; bus.mem_ready = 0; bus.mem_rdata = 8'hEE;
    tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_addr !== 16'hF200 || bus.mem_wdata !== 8'hC3) begin failures++; $display("FAIL wr_addr got we=%b re=%b addr=%h wd=%h exp 1 0 f200 c3", bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata); end
    for (int i = 2; i <= 6; i++) tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL wr_held got we=%b ack=%b exp 1 0", bus.mem_we, bus.cpu_ack); end
    bus.mem_ready = 1;
    tick();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.mem_we !== 1'b0 || bus.rdata !== 8'h5A) begin failures++; $display("FAIL wr_ack got ack=%b we=%b rdata=%h exp 1 0 5a", bus.cpu_ack, bus.mem_we, bus.rdata); end
    bus.cpu_req = 0;
    tick();
  endtask
  task automatic test_round_robin();
    int exp_own [5] = '{1, 0, 2, 0, 1};
    logic [15:0] exp_addr [3] = '{16'h1000, 16'h2000, 16'h3000};
    int n;
    bus.cpu_we = 0; bus.cpu_addr = 16'h1000; bus.dma_we = 2'b00; bus.dma_addr = {16'h3000, 16'h2000};
    bus.mem_rdata = 8'h3C; bus.mem_ready = 1;
    bus.cpu_req = 1; bus.dma_req = 2'b11;
    for (int a = 0; a < 5; a++) begin
      n = 0;
      do begin tick(); n++; end while (!(bus.cpu_ack || (|bus.dma_ack)) && n < 20);
      if (a == 4) begin bus.cpu_req = 0; bus.dma_req = 2'b00; end
      checks++; if (n !== (a == 0 ? 4 : 5)) begin failures++; $display("FAIL rr_latency[%0d] got %0d cycles exp %0d", a, n, (a == 0 ? 4 : 5)); end
      checks++; if (bus.owner !== 3'(exp_own[a]) || bus.cpu_ack !== (exp_own[a] == 0) || bus.dma_ack !== (exp_own[a] == 0 ? 2'b00 : 2'(1 << (exp_own[a] - 1)))) begin failures++; $display("FAIL rr_grant[%0d] got owner=%0d cpu=%b dma=%b exp owner=%0d", a, bus.owner, bus.cpu_ack, bus.dma_ack, exp_own[a]); end
      checks++; if (bus.mem_addr !== exp_addr[exp_own[a]] || bus.rdata !== 8'h3C) begin failures++; $display("FAIL rr_data[%0d] got addr=%h rdata=%h exp %h 3c", a, bus.mem_addr, bus.rdata, exp_addr[exp_own[a]]); end
    end
    tick();
    checks++; if (bus.cpu_ack !== 1'b0 || bus.dma_ack !== 2'b00) begin failures++; $display("FAIL rr_single_ack got cpu=%b dma=%b exp 0 00", bus.cpu_ack, bus.dma_ack); end
    tick(); tick();
  endtask
  task automatic test_reset_abort();
    int n;
    bus.dma_req = 2'b10; bus.dma_we = 2'b10; bus.dma_addr = {16'h4000, 16'h0000}; bus.dma_wdata = {8'h77, 8'h00}; bus.mem_ready = 0;
    tick(); tick(); tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.owner !== 3'd2 || bus.mem_addr !== 16'h4000) begin failures++; $display("FAIL abort_pre got we=%b owner=%0d addr=%h exp 1 2 4000", bus.mem_we, bus.owner, bus.mem_addr); end
    reset = 1;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0 || bus.owner !== 3'd0 || bus.dma_ack !== 2'b00) begin failures++; $display("FAIL abort_now got we=%b re=%b owner=%0d ack=%b exp 0 0 0 00", bus.mem_we, bus.mem_re, bus.owner, bus.dma_ack); end
    bus.mem_ready = 1;
    tick(); tick();
    checks++; if (bus.dma_ack !== 2'b00 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL abort_hold got ack=%b we=%b exp 00 0", bus.dma_ack, bus.mem_we); end
    reset = 0;
    n = 0;
    do begin tick(); n++; end while (bus.dma_ack === 2'b00 && n < 20);
    bus.dma_req = 2'b00;
    checks++; if (n !== 4 || bus.dma_ack !== 2'b10 || bus.owner !== 3'd2) begin failures++; $display("FAIL abort_redo got n=%0d ack=%b owner=%0d exp 4 10 2", n, bus.dma_ack, bus.owner); end
    checks++; if (bus.mem_wdata !== 8'h77 || bus.rdata !== 8'h00) begin failures++; $display("FAIL abort_redo_data got wd=%h rdata=%h exp 77 00", bus.mem_wdata, bus.rdata); end
    tick(); tick();
  endtask
`ifdef CPU6_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0200; bus.mem_ready = 0;
    n = 0;
    do begin tick(); n++; end while (!bus.cpu_ack && n < 60);
    bus.cpu_req = 0;
    checks++; if (bus.cpu_ack !== 1'b1 || bus.bus_error !== 1'b1 || bus.rdata !== 8'hFF) begin failures++; $display("FAIL tmo_ack got ack=%b err=%b rdata=%h exp 1 1 ff", bus.cpu_ack, bus.bus_error, bus.rdata); end
    tick(); tick();
    bus.mem_ready = 1; bus.mem_rdata = 8'h11; bus.cpu_req = 1;
    n = 0;
    do begin tick(); n++; end while (!bus.cpu_ack && n < 20);
    bus.cpu_req = 0;
    checks++; if (bus.cpu_ack !== 1'b1 || bus.bus_error !== 1'b0 || bus.rdata !== 8'h11) begin failures++; $display("FAIL tmo_clear got ack=%b err=%b rdata=%h exp 1 0 11", bus.cpu_ack, bus.bus_error, bus.rdata); end
    tick();
  endtask
`endif
  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write_wait();
    test_round_robin();
    test_reset_abort();
`ifdef CPU6_BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
